// File: rtl/viterbi_pkg.sv
// Shared types and default constants for the viterbi stream checker.
package viterbi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam int unsigned CHK_LANES      = 1;
    localparam int unsigned CHK_NUM_BITS   = 512;
    localparam int unsigned CHK_FIFO_DEPTH = 64;
    localparam int unsigned CHK_CNT_W      = 32;

endpackage

// File: rtl/viterbi_chk_fifo.sv
// Synchronous FIFO for expected beats: registered storage, no write-to-read bypass,
// flush empties it in one cycle.
module viterbi_chk_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/viterbi_stream_checker.sv
// Compares decoded beats against buffered expected beats and counts bit errors per run.
// Optional first-error logging is enabled by defining VITERBI_CHK_ERR_LOG_EN.
module viterbi_stream_checker
    import viterbi_pkg::*;
#(
    parameter int unsigned LANES      = CHK_LANES,
    parameter int unsigned NUM_BITS   = CHK_NUM_BITS,
    parameter int unsigned FIFO_DEPTH = CHK_FIFO_DEPTH,
    parameter int unsigned CNT_W      = CHK_CNT_W
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic             exp_valid,
    input  logic [LANES-1:0] exp_bits,
    output logic             exp_ready,
    input  logic             dec_valid,
    input  logic [LANES-1:0] dec_bits,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] error_cnt,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int unsigned PW = $clog2(LANES + 1);
    localparam logic [CNT_W:0] RUN_BITS = (CNT_W + 1)'(NUM_BITS);

    chk_state_t       state;
    chk_state_t       state_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LANES-1:0] head;
    logic [LANES-1:0] mism;
    logic [PW-1:0]    err_bits;
    logic [PW-1:0]    ok_bits;
    logic [CNT_W:0]   compared;
    logic             run_full;
    logic             active;
    logic             beat_cmp;
    logic             beat_under;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PW-1:0]    b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    viterbi_chk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LANES)
    ) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .flush (start),
        .push  (exp_valid && exp_ready),
        .wdata (exp_bits),
        .pop   (beat_cmp),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Once the run's bit budget is reached, further beats are dropped while DONE settles.
    assign compared   = {1'b0, correct_cnt} + {1'b0, error_cnt};
    assign run_full   = (compared >= RUN_BITS);
    assign active     = (state == RUN) && !start && !run_full;
    assign beat_cmp   = active && dec_valid && !fifo_empty;
    assign beat_under = active && dec_valid && fifo_empty;
    assign mism       = head ^ dec_bits;
    assign ok_bits    = PW'(LANES) - err_bits;

    always_comb begin
        err_bits = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            err_bits = err_bits + PW'(mism[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (start) state_nxt = RUN;
                     else if (run_full) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        exp_ready = (state == RUN) && !fifo_full;
    end

    always_ff @(posedge clk) begin
        if (RST || start) begin
            correct_cnt <= '0;
            error_cnt   <= '0;
            underrun    <= 1'b0;
        end else begin
            if (beat_cmp) begin
                correct_cnt <= sat_add(correct_cnt, ok_bits);
                error_cnt   <= sat_add(error_cnt, err_bits);
            end
            if (beat_under) underrun <= 1'b1;
        end
    end

`ifdef VITERBI_CHK_ERR_LOG_EN
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0] first_lane;
    logic          lane_found;

    always_comb begin
        first_lane = '0;
        lane_found = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mism[i] && !lane_found) begin
                first_lane = LW'(i);
                lane_found = 1'b1;
            end
        end
    end

    // Bits compared so far equals the stream index of the current beat's lane 0.
    always_ff @(posedge clk) begin
        if (RST || start) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (beat_cmp && lane_found && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= compared[CNT_W-1:0] + CNT_W'(first_lane);
        end
    end
`else
    assign first_err_vld = 1'b0;
    assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_viterbi_stream_checker.sv
// Directed scoreboard bench for viterbi_stream_checker (LANES=1 and LANES=2 instances).
module tb_viterbi_stream_checker;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    // LANES=1, NUM_BITS=512 instance
    logic        start1 = 1'b0, exp_valid1 = 1'b0, dec_valid1 = 1'b0;
    logic [0:0]  exp_bits1 = '0, dec_bits1 = '0;
    logic        exp_ready1, busy1, done1, underrun1, fvld1;
    logic [31:0] correct1, error1, fidx1;

    // LANES=2, NUM_BITS=1024 instance
    logic        start2 = 1'b0, exp_valid2 = 1'b0, dec_valid2 = 1'b0;
    logic [1:0]  exp_bits2 = '0, dec_bits2 = '0;
    logic        exp_ready2, busy2, done2, underrun2, fvld2;
    logic [31:0] correct2, error2, fidx2;

    viterbi_stream_checker #(
        .LANES(1), .NUM_BITS(512), .FIFO_DEPTH(64), .CNT_W(32)
    ) dut1 (
        .clk(clk), .RST(RST), .start(start1),
        .exp_valid(exp_valid1), .exp_bits(exp_bits1), .exp_ready(exp_ready1),
        .dec_valid(dec_valid1), .dec_bits(dec_bits1),
        .correct_cnt(correct1), .error_cnt(error1), .busy(busy1), .done(done1),
        .underrun(underrun1), .first_err_vld(fvld1), .first_err_idx(fidx1)
    );

    viterbi_stream_checker #(
        .LANES(2), .NUM_BITS(1024), .FIFO_DEPTH(64), .CNT_W(32)
    ) dut2 (
        .clk(clk), .RST(RST), .start(start2),
        .exp_valid(exp_valid2), .exp_bits(exp_bits2), .exp_ready(exp_ready2),
        .dec_valid(dec_valid2), .dec_bits(dec_bits2),
        .correct_cnt(correct2), .error_cnt(error2), .busy(busy2), .done(done2),
        .underrun(underrun2), .first_err_vld(fvld2), .first_err_idx(fidx2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic       sb1[$];
    logic [1:0] sb2[$];

    int unsigned m_cor, m_err, m_idx, m_first;
    bit          m_fvld, m_under;
    int          flip_at[3];

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb1.delete();
        m_cor = 0; m_err = 0; m_idx = 0; m_first = 0; m_fvld = 0; m_under = 0;
        flip_at[0] = -1; flip_at[1] = -1; flip_at[2] = -1;
    endtask

    task automatic start_run1();
        @(negedge clk);
        start1 = 1'b1; exp_valid1 = 1'b0; dec_valid1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        model_clear();
    endtask

    // One cycle on dut1: optional push of a random expected bit, optional decoded beat.
    task automatic beat1(input bit push, input bit pop);
        logic b, h, f;
        @(negedge clk);
        b = 1'($urandom);
        exp_valid1 = push;
        exp_bits1  = b;
        if (push && exp_ready1) sb1.push_back(b);
        dec_valid1 = pop;
        dec_bits1  = '0;
        if (pop) begin
            if (sb1.size() == 0) begin
                m_under = 1;
            end else begin
                h = sb1.pop_front();
                f = (int'(m_idx) == flip_at[0]) || (int'(m_idx) == flip_at[1]) ||
                    (int'(m_idx) == flip_at[2]);
                dec_bits1 = h ^ f;
                if (f) begin
                    m_err++;
                    if (!m_fvld) begin m_fvld = 1; m_first = m_idx; end
                end else begin
                    m_cor++;
                end
                m_idx++;
            end
        end
    endtask

    task automatic idle1();
        @(negedge clk);
        exp_valid1 = 1'b0; dec_valid1 = 1'b0;
    endtask

    task automatic run_stream(input int n);
        for (int k = 0; k <= n; k++) beat1(k < n, k >= 1);
        idle1();
    endtask

    task automatic check_counts1(input string tag);
        chk({tag, ".correct"}, 64'(correct1), 64'(m_cor));
        chk({tag, ".error"},   64'(error1),   64'(m_err));
        chk({tag, ".underrun"}, 64'(underrun1), 64'(m_under));
`ifdef VITERBI_CHK_ERR_LOG_EN
        chk({tag, ".fvld"}, 64'(fvld1), 64'(m_fvld));
        if (m_fvld) chk({tag, ".fidx"}, 64'(fidx1), 64'(m_first));
`else
        chk({tag, ".fvld"}, 64'(fvld1), 64'd0);
`endif
    endtask

    task automatic wait_done1(input string tag);
        for (int i = 0; i < 20 && !done1; i++) @(negedge clk);
        chk({tag, ".done"}, 64'(done1), 64'd1);
        chk({tag, ".busy"}, 64'(busy1), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] b2, h2, f2;
        int unsigned m2_cor, m2_err;

        model_clear();
        repeat (3) @(negedge clk);
        chk("reset.busy",      64'(busy1),      64'd0);
        chk("reset.done",      64'(done1),      64'd0);
        chk("reset.exp_ready", 64'(exp_ready1), 64'd0);
        chk("reset.correct",   64'(correct1),   64'd0);
        chk("reset.error",     64'(error1),     64'd0);
        chk("reset.underrun",  64'(underrun1),  64'd0);
        chk("reset.fvld",      64'(fvld1),      64'd0);
        RST = 1'b0;

        // Underrun: decoded beat with nothing buffered, then normal matched beats.
        start_run1();
        chk("t4.busy", 64'(busy1), 64'd1);
        beat1(0, 1);
        idle1();
        check_counts1("t4.under");
        run_stream(4);
        check_counts1("t4.after");

        // Full clean run.
        start_run1();
        chk("t1.underrun_cleared", 64'(underrun1), 64'd0);
        run_stream(512);
        wait_done1("t1");
        check_counts1("t1");
        chk("t1.exp_ready_done", 64'(exp_ready1), 64'd0);
        @(negedge clk);
        dec_valid1 = 1'b1; dec_bits1 = 1'b1; exp_valid1 = 1'b1;
        idle1();
        check_counts1("t1.post_done");
        chk("t1.still_done", 64'(done1), 64'd1);

        // Run with three flipped bits including the last one.
        start_run1();
        flip_at[0] = 10; flip_at[1] = 200; flip_at[2] = 511;
        run_stream(512);
        wait_done1("t2");
        check_counts1("t2");
        chk("t2.error_const", 64'(error1), 64'd3);

        // FIFO full, then push and pop together at occupancy 63.
        start_run1();
        for (int k = 0; k < 64; k++) beat1(1, 0);
        idle1();
        chk("t5.full_ready", 64'(exp_ready1), 64'd0);
        beat1(1, 1);
        for (int k = 0; k < 8; k++) begin
            beat1(1, 1);
            chk("t5.pushpop_ready", 64'(exp_ready1), 64'd1);
        end
        idle1();
        chk("t5.held_ready", 64'(exp_ready1), 64'd1);
        for (int k = 0; k < 63; k++) beat1(0, 1);
        idle1();
        check_counts1("t5.drain");
        chk("t5.queue_empty", 64'(sb1.size()), 64'd0);

        // Restart mid-run, then reset mid-run with start and beats present.
        start_run1();
        run_stream(300);
        start_run1();
        check_counts1("t6.restart");
        chk("t6.busy", 64'(busy1), 64'd1);
        run_stream(100);
        check_counts1("t6.second");
        @(negedge clk);
        RST = 1'b1; start1 = 1'b1; exp_valid1 = 1'b1; dec_valid1 = 1'b1;
        @(negedge clk);
        RST = 1'b0; start1 = 1'b0; exp_valid1 = 1'b0; dec_valid1 = 1'b0;
        model_clear();
        chk("t6.rst_busy",      64'(busy1),      64'd0);
        chk("t6.rst_done",      64'(done1),      64'd0);
        chk("t6.rst_exp_ready", 64'(exp_ready1), 64'd0);
        check_counts1("t6.rst");

        // LANES=2: lane-1 flip on beat 5.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        sb2.delete();
        m2_cor = 0; m2_err = 0;
        for (int k = 0; k <= 512; k++) begin
            @(negedge clk);
            b2 = 2'($urandom);
            exp_valid2 = (k < 512);
            exp_bits2  = b2;
            if (k < 512) sb2.push_back(b2);
            dec_valid2 = (k >= 1);
            if (k >= 1) begin
                h2 = sb2.pop_front();
                f2 = (k - 1 == 5) ? 2'b10 : 2'b00;
                dec_bits2 = h2 ^ f2;
                m2_err += $countones(f2);
                m2_cor += 2 - $countones(f2);
            end
        end
        @(negedge clk);
        exp_valid2 = 1'b0; dec_valid2 = 1'b0;
        for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
        chk("t3.done",    64'(done2),    64'd1);
        chk("t3.correct", 64'(correct2), 64'(m2_cor));
        chk("t3.error",   64'(error2),   64'd1);
        chk("t3.underrun", 64'(underrun2), 64'd0);
`ifdef VITERBI_CHK_ERR_LOG_EN
        chk("t3.fvld", 64'(fvld2), 64'd1);
        chk("t3.fidx", 64'(fidx2), 64'd11);
`else
        chk("t3.fvld", 64'(fvld2), 64'd0);
        chk("t3.fidx", 64'(fidx2), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
